// File: rtl/xw_enc_pkg.sv
// Shared definitions for the registered 8-to-3 priority encoder.
//   A_IDLE_L    : active-low code driven when no line is active / disabled
//   N_LINES     : number of request lines
//   enc_state_t : press-tracking FSM states
package xw_enc_pkg;

    localparam int         N_LINES  = 8;
    localparam logic [2:0] A_IDLE_L = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } enc_state_t;

endpackage

// File: rtl/xw_debounce_line.sv
// One request line: 2-FF synchroniser followed by a counter debouncer.
// The debounced level flips only after DEB_CYCLES consecutive clocks on
// which the synchronised level disagrees with it.
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   din_l  in  raw asynchronous line (active-low)
//   db_l   out debounced level (active-low, resets inactive high)
module xw_debounce_line #(
    parameter  int DEB_CYCLES = 4,
    localparam int CNT_W      = $clog2(DEB_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_l,
    output logic db_l
);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q,    db_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sync1_d = din_l;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                // Last mismatch clock of the run: accept the new level.
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample
    // pre-edge values; the reset is synchronous, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_l = db_q;

endmodule

// File: rtl/xw_prio_encoder_sync.sv
// Registered 74148-style 8-to-3 priority encoder with debounced inputs and
// a valid/ack event latch that reports each new highest-priority press once.
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   ei_l         in   enable, active-low, asynchronous (synchronised only)
//   i_l[7:0]     in   request lines, active-low, bit 7 highest priority
//   a_l[2:0]     out  encoded index of highest active line, active-low
//   gs_l         out  low when enabled and a debounced line is active
//   eo_l         out  low when enabled and no debounced line is active
//   evt_valid    out  new-press event pending
//   evt_code     out  active-high index of the event's line
//   evt_ack      in   consumer acknowledge (only meaningful while valid)
//   evt_overrun  out  sticky: an unacknowledged event was overwritten
module xw_prio_encoder_sync
    import xw_enc_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ei_l,
    input  logic [7:0] i_l,
    output logic [2:0] a_l,
    output logic       gs_l,
    output logic       eo_l,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    input  logic       evt_ack,
    output logic       evt_overrun
);

    logic [N_LINES-1:0] db_l;

    for (genvar k = 0; k < N_LINES; k++) begin : g_line
        xw_debounce_line #(.DEB_CYCLES(DEB_CYCLES)) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .din_l (i_l[k]),
            .db_l  (db_l[k])
        );
    end

    logic       ei_sync1_q, ei_sync1_d;
    logic       ei_sync2_q, ei_sync2_d;
    logic [2:0] a_q,        a_d;
    logic       gs_q,       gs_d;
    logic       eo_q,       eo_d;
    enc_state_t state_q,    state_d;
    logic [2:0] held_q,     held_d;
    logic       valid_q,    valid_d;
    logic [2:0] code_q,     code_d;
    logic       ovr_q,      ovr_d;
    logic       raise;
    logic       ack_take;
    logic [2:0] code_now;

    // Encoder stage: ascending scan, so the highest active line wins.
    always_comb begin
        ei_sync1_d = ei_l;
        ei_sync2_d = ei_sync1_q;
        a_d        = A_IDLE_L;
        gs_d       = 1'b1;
        eo_d       = 1'b1;
        if (!ei_sync2_q) begin
            eo_d = 1'b0;
            for (int i = 0; i < N_LINES; i++) begin
                if (!db_l[i]) begin
                    a_d  = ~3'(i);
                    gs_d = 1'b0;
                    eo_d = 1'b1;
                end
            end
        end
    end

    // Press tracker, driven from the registered encoder outputs.
    always_comb begin
        code_now = ~a_q;
        state_d  = state_q;
        held_d   = held_q;
        raise    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!gs_q) begin
                    state_d = HELD;
                    raise   = 1'b1;
                    held_d  = code_now;
                end
            end
            HELD: begin
                if (gs_q) begin
                    state_d = IDLE;
                end else if (code_now != held_q) begin
                    // Higher press, or a higher line released exposing a lower one.
                    raise  = 1'b1;
                    held_d = code_now;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Event latch and handshake.
    always_comb begin
        ack_take = evt_ack && valid_q;
        valid_d  = valid_q;
        code_d   = code_q;
        ovr_d    = ovr_q;
        if (raise) begin
            valid_d = 1'b1;
            code_d  = code_now;
            if (ack_take) begin
                ovr_d = 1'b0;
            end else if (valid_q) begin
                ovr_d = 1'b1;
            end
        end else if (ack_take) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ei_sync1_q <= 1'b1;
            ei_sync2_q <= 1'b1;
            a_q        <= A_IDLE_L;
            gs_q       <= 1'b1;
            eo_q       <= 1'b1;
            state_q    <= IDLE;
            held_q     <= '0;
            valid_q    <= 1'b0;
            code_q     <= '0;
            ovr_q      <= 1'b0;
        end else begin
            ei_sync1_q <= ei_sync1_d;
            ei_sync2_q <= ei_sync2_d;
            a_q        <= a_d;
            gs_q       <= gs_d;
            eo_q       <= eo_d;
            state_q    <= state_d;
            held_q     <= held_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            ovr_q      <= ovr_d;
        end
    end

    assign a_l         = a_q;
    assign gs_l        = gs_q;
    assign eo_l        = eo_q;
    assign evt_valid   = valid_q;
    assign evt_code    = code_q;
    assign evt_overrun = ovr_q;

endmodule

// File: tb/tb_xw_prio_encoder_sync.sv
// Bench for xw_prio_encoder_sync (DEB_CYCLES=4): directed timing/handshake
// scenarios, then randomized press patterns scored against a queue of
// expected event codes that a monitor drains as the DUT presents events.
module tb_xw_prio_encoder_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ei_l;
    logic [7:0] i_l;
    logic [2:0] a_l;
    logic       gs_l;
    logic       eo_l;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ack;
    logic       evt_overrun;

    logic man_ack = 1'b0;
    logic mon_ack = 1'b0;
    logic auto_ack = 1'b0;
    assign evt_ack = man_ack | mon_ack;

    int compared   = 0;
    int mismatched = 0;
    int sb[$];

    xw_prio_encoder_sync #(.DEB_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ei_l        (ei_l),
        .i_l         (i_l),
        .a_l         (a_l),
        .gs_l        (gs_l),
        .eo_l        (eo_l),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_ack     (evt_ack),
        .evt_overrun (evt_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_once();
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
    endtask

    // Highest active (low) line of a pattern, -1 when none.
    function automatic int top_idx(input logic [7:0] p);
        for (int i = 7; i >= 0; i--) if (!p[i]) return i;
        return -1;
    endfunction

    // Monitor: whenever an event is presented, score it and acknowledge it.
    always @(negedge clk) begin
        if (auto_ack) begin
            if (mon_ack) begin
                mon_ack = 1'b0;
            end else if (evt_valid) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL evt_unexpected: got code %0d expected no event", evt_code);
                end else begin
                    check("evt_code_sb", int'(evt_code), sb.pop_front());
                end
                check("evt_overrun_sb", int'(evt_overrun), 0);
                mon_ack = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] prev;
        logic [7:0] p;
        int         held;
        int         n;

        // 1. Reset values, then first-press latency from reset release.
        rst_n = 1'b0; ei_l = 1'b0; i_l = 8'h00;
        tick(2);
        check("rst_a_l", int'(a_l), 7);
        check("rst_gs_l", int'(gs_l), 1);
        check("rst_eo_l", int'(eo_l), 1);
        check("rst_evt_valid", int'(evt_valid), 0);
        check("rst_evt_code", int'(evt_code), 0);
        check("rst_evt_overrun", int'(evt_overrun), 0);
        rst_n = 1'b1;
        tick(6);
        check("rst_gs_l_e5", int'(gs_l), 1);
        tick(1);
        check("rst_gs_l_e6", int'(gs_l), 0);
        check("rst_a_l_e6", int'(a_l), 0);
        tick(1);
        check("rst_evt_valid_e7", int'(evt_valid), 1);
        check("rst_evt_code_e7", int'(evt_code), 7);
        ack_once();
        i_l = 8'hFF;
        tick(10);

        // 2. Single press of line 2.
        i_l = 8'hFB;
        tick(7);
        check("sp_a_l", int'(a_l), 3'b101);
        check("sp_gs_l", int'(gs_l), 0);
        check("sp_eo_l", int'(eo_l), 1);
        check("sp_valid_e6", int'(evt_valid), 0);
        tick(1);
        check("sp_valid_e7", int'(evt_valid), 1);
        check("sp_code", int'(evt_code), 2);
        ack_once();
        check("sp_ack", int'(evt_valid), 0);
        i_l = 8'hFF;
        tick(10);

        // 3. Glitch on line 5: 3 clocks ignored, 4 clocks accepted.
        i_l = 8'hDF;
        tick(3);
        i_l = 8'hFF;
        tick(10);
        check("gl3_gs_l", int'(gs_l), 1);
        check("gl3_a_l", int'(a_l), 7);
        check("gl3_valid", int'(evt_valid), 0);
        i_l = 8'hDF;
        tick(4);
        i_l = 8'hFF;
        tick(8);
        check("gl4_valid", int'(evt_valid), 1);
        check("gl4_code", int'(evt_code), 5);
        ack_once();
        tick(4);

        // 4. Priority and overrun.
        i_l = 8'hBB;
        tick(8);
        check("pr_a_l", int'(a_l), 3'b001);
        check("pr_code", int'(evt_code), 6);
        check("pr_valid", int'(evt_valid), 1);
        i_l = 8'hFB;
        tick(8);
        check("pr_rel_a_l", int'(a_l), 3'b101);
        check("pr_rel_code", int'(evt_code), 2);
        check("pr_rel_ovr", int'(evt_overrun), 1);
        ack_once();
        check("pr_ack_valid", int'(evt_valid), 0);
        check("pr_ack_ovr", int'(evt_overrun), 0);

        // 5. Raise landing on the same clock as an ack.
        i_l = 8'hF3;
        tick(8);
        check("sim_pre_code", int'(evt_code), 3);
        check("sim_pre_valid", int'(evt_valid), 1);
        i_l = 8'hD3;
        tick(7);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        check("sim_valid", int'(evt_valid), 1);
        check("sim_code", int'(evt_code), 5);
        check("sim_ovr", int'(evt_overrun), 0);
        ack_once();
        check("sim_ack_valid", int'(evt_valid), 0);

        // 6. Enable deasserted while line 4 held, then reset mid-debounce.
        i_l = 8'hEF;
        tick(8);
        check("en_code", int'(evt_code), 4);
        ei_l = 1'b1;
        tick(4);
        check("en_off_gs_l", int'(gs_l), 1);
        check("en_off_eo_l", int'(eo_l), 1);
        check("en_off_a_l", int'(a_l), 7);
        check("en_off_valid", int'(evt_valid), 1);
        check("en_off_code", int'(evt_code), 4);
        ack_once();
        check("en_off_ack", int'(evt_valid), 0);
        ei_l = 1'b0;
        tick(5);
        check("en_on_valid", int'(evt_valid), 1);
        check("en_on_code", int'(evt_code), 4);
        i_l = 8'h7F;
        tick(4);
        rst_n = 1'b0; i_l = 8'hFF;
        tick(1);
        check("mid_rst_valid", int'(evt_valid), 0);
        check("mid_rst_ovr", int'(evt_overrun), 0);
        check("mid_rst_gs_l", int'(gs_l), 1);
        rst_n = 1'b1;
        tick(12);
        check("post_rst_valid", int'(evt_valid), 0);
        check("post_rst_gs_l", int'(gs_l), 1);

        // 7. Randomized press patterns with glitches, scoreboard-checked.
        auto_ack = 1'b1;
        prev = 8'hFF;
        held = -1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                i_l = prev ^ (8'h01 << $urandom_range(0, 7));
                tick($urandom_range(1, 3));
                i_l = prev;
                tick(4);
            end
            case ($urandom_range(0, 3))
                0:       p = 8'hFF;
                1:       p = 8'($urandom);
                default: p = 8'($urandom | $urandom | $urandom);
            endcase
            n = top_idx(p);
            if (n >= 0 && n != held) sb.push_back(n);
            held = n;
            i_l  = p;
            prev = p;
            tick(9);
            check("rnd_gs_l", int'(gs_l), (n < 0) ? 1 : 0);
            check("rnd_eo_l", int'(eo_l), (n < 0) ? 0 : 1);
            check("rnd_a_l", int'(a_l), (n < 0) ? 7 : 7 - n);
        end
        tick(10);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
